code_entry: RTL and testbench

CODE_ENTRY -- requirements
Module: code_entry

---
 rtl/code_entry.sv | 196 +++++++++++++++++++
 tb/tb_code_entry.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/code_entry.sv
// ============================================================================
// code_entry -- debounced four-button code entry with a confirm button.
//
// Four raw code buttons toggle the bits of a 4-bit code (q,u,n,b). A confirm
// button (ok) presents the code to the lock by raising d, and a second
// confirm press withdraws it and clears the code.
//
// Signal path, per button:
//   raw -> two-flop synchronizer -> debounce counter / debounced state
//       -> registered press pulse -> FSM.
// A press held stable shows up on q/u/n/b or d on the (DB_CYCLES+3)-th clk
// edge after the raw input goes low (the first edge that samples it counts
// as the first).
//
// Optional feature (macro AUTO_CLEAR_EN, undefined by default):
//   an inactivity timer clears the code and drops back to IDLE after
//   TIMEOUT_CYCLES cycles without a press event or a state change.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   key_in[3:0]  raw code buttons, active-low, bit3..0 = q,u,n,b
//   ok_in        raw confirm button, active-low
//   q,u,n,b      registered code bits
//   d            code presented for checking (state == ARMED)
//   armed        status LED, same as d
// ============================================================================
module code_entry #(
    parameter int DB_CYCLES      = 240000,
    parameter int TIMEOUT_CYCLES = 120000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    input  logic       ok_in,
    output logic       q,
    output logic       u,
    output logic       n,
    output logic       b,
    output logic       d,
    output logic       armed
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    // Elaboration-time guard on the window parameters.
    if (DB_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("code_entry: DB_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and debouncers. Index 4 is ok, 3..0 are the keys.
    // All buttons idle high (released).
    // ------------------------------------------------------------------
    logic [4:0]      raw;
    logic [4:0]      sync1_q, sync2_q;
    logic [4:0]      db_q, db_d;
    logic [4:0]      press_q, press_d;
    logic [DB_W-1:0] cnt_q [5];
    logic [DB_W-1:0] cnt_d [5];

    assign raw = {ok_in, key_in};

    always_comb begin
        db_d    = db_q;
        press_d = '0;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    // Stable long enough: accept the new level. Only a
                    // falling (press) transition produces an event.
                    db_d[i]    = sync2_q[i];
                    press_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            press_q <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] code_q, code_d;
    logic [3:0] key_ev;
    logic       ok_ev;

    assign key_ev = press_q[3:0];
    assign ok_ev  = press_q[4];

`ifdef AUTO_CLEAR_EN
    localparam int TM_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TM_W-1:0] TM_MAX = TM_W'(TIMEOUT_CYCLES - 1);

    logic [TM_W-1:0] tmr_q, tmr_d;
    logic            any_ev;
    logic            timeout;

    assign any_ev  = |press_q;
    // A press event in the same cycle always wins over the timeout.
    assign timeout = (tmr_q == TM_MAX) && !any_ev;
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                // ok has priority: simultaneous key events are dropped and
                // the pre-toggle code is the one armed.
                if (ok_ev) begin
                    state_d = ARMED;
                end else begin
                    code_d = code_q ^ key_ev;
                end
            end
            ARMED: begin
                if (ok_ev) begin
                    state_d = IDLE;
                    code_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
            end
        endcase
`ifdef AUTO_CLEAR_EN
        if (timeout) begin
            state_d = IDLE;
            code_d  = '0;
        end
`endif
    end

`ifdef AUTO_CLEAR_EN
    always_comb begin
        tmr_d = tmr_q + 1'b1;
        // Timeout also restarts the count so an empty IDLE simply wraps.
        if (any_ev || (state_d != state_q) || timeout) begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    assign {q, u, n, b} = code_q;
    assign d            = (state_q == ARMED);
    assign armed        = (state_q == ARMED);

endmodule

// File: tb/tb_code_entry.sv
// ============================================================================
// tb_code_entry -- directed bench for code_entry (DB_CYCLES=4,
// TIMEOUT_CYCLES=50). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so a press driven before edge E0
// must be visible after the 7th edge (E0+6) and not after the 6th.
// Build with +define+AUTO_CLEAR_EN to exercise the inactivity timer.
// ============================================================================
module tb_code_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       ok_in;
    logic       q, u, n, b, d, armed;

    int n_tests = 0;
    int n_fail  = 0;

    code_entry #(
        .DB_CYCLES     (4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_in),
        .ok_in (ok_in),
        .q     (q),
        .u     (u),
        .n     (n),
        .b     (b),
        .d     (d),
        .armed (armed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] code_exp, input logic arm_exp);
        check({tag, ".code"},  {4'h0, q, u, n, b}, {4'h0, code_exp});
        check({tag, ".d"},     {7'h0, d},          {7'h0, arm_exp});
        check({tag, ".armed"}, {7'h0, armed},      {7'h0, arm_exp});
    endtask

    // Press the selected buttons (held 10 cycles), check the exact edge the
    // result appears on, release, then wait for the release to settle.
    // Ends 13 edges after the edge on which the result appears.
    task automatic press(input string tag, input logic [3:0] keys, input logic ok,
                         input logic [3:0] code_pre, input logic arm_pre,
                         input logic [3:0] code_post, input logic arm_post);
        key_in = ~keys;
        ok_in  = ~ok;
        repeat (6) tick();
        check_out({tag, ".before"}, code_pre, arm_pre);
        tick();
        check_out({tag, ".after"}, code_post, arm_post);
        repeat (3) tick();
        key_in = 4'hF;
        ok_in  = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        key_in = 4'hF;
        ok_in  = 1'b1;
        rst    = 1'b1;
        repeat (3) tick();
        check_out("reset", 4'b0000, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        check_out("reset_release", 4'b0000, 1'b0);

        // 3-cycle glitch on key_in[3] is filtered out.
        key_in = 4'b0111;
        repeat (3) tick();
        key_in = 4'hF;
        repeat (12) tick();
        check_out("glitch", 4'b0000, 1'b0);

        // Toggle q then b.
        press("key_q", 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0);
        press("key_b", 4'b0001, 1'b0, 4'b1000, 1'b0, 4'b1001, 1'b0);

        // Arm, ignore a key while armed, disarm clears the code.
        press("arm",        4'b0000, 1'b1, 4'b1001, 1'b0, 4'b1001, 1'b1);
        press("key_armed",  4'b0010, 1'b0, 4'b1001, 1'b1, 4'b1001, 1'b1);
        press("disarm",     4'b0000, 1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0);

        // ok and key_in[2] together: ok wins, key discarded.
        press("ok_and_key", 4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
        press("disarm2",    4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Two keys at once toggle both bits, then arm 0110 and reset.
        press("two_keys",   4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b0);
        press("arm_0110",   4'b0000, 1'b1, 4'b0110, 1'b0, 4'b0110, 1'b1);
        rst = 1'b1;
        tick();
        check_out("rst_armed", 4'b0000, 1'b0);
        rst = 1'b0;
        repeat (12) tick();
        check_out("rst_armed_after", 4'b0000, 1'b0);

        // Reset in the middle of a debounce with the button still held:
        // exactly one event, counted from reset release.
        key_in = 4'b0111;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        check_out("held_rst.before", 4'b0000, 1'b0);
        tick();
        check_out("held_rst.after", 4'b1000, 1'b0);
        repeat (10) tick();
        check_out("held_rst.hold", 4'b1000, 1'b0);
        key_in = 4'hF;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_out("clear_rst", 4'b0000, 1'b0);

`ifdef AUTO_CLEAR_EN
        // Event edge T; press() returns at T+13. Timeout fires at T+50.
        press("tmr_key", 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0);
        repeat (36) tick();
        check_out("tmr_idle.before", 4'b0010, 1'b0);
        tick();
        check_out("tmr_idle.after", 4'b0000, 1'b0);

        press("tmr_key2", 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0);
        press("tmr_arm",  4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1);
        repeat (36) tick();
        check_out("tmr_armed.before", 4'b0010, 1'b1);
        tick();
        check_out("tmr_armed.after", 4'b0000, 1'b0);
`else
        press("hold_key", 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0);
        repeat (200) tick();
        check_out("hold_idle", 4'b0010, 1'b0);
        press("hold_arm", 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1);
        repeat (200) tick();
        check_out("hold_armed", 4'b0010, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
